// File: rtl/wide_compare_seq.sv
// Multi-word compare sequencer: one shared word comparator, most-significant word first.
// Optional CMP_SIGNED_EN: two's-complement operands via MSB bias on the top word.
module c_alu #(
   parameter int unsigned W = 16
) (
   input  logic [1:0]   op,
   input  logic [W-1:0] in0,
   input  logic [W-1:0] in1,
   output logic         out
);
   always_comb begin
      out = 1'b0;
      case (op)
         2'b00: out = (in0 == in1);
         2'b01: out = (in0 <  in1);
         2'b10: out = (in0 != in1);
         2'b11: out = (in0 >= in1);
         default: out = 1'b0;
      endcase
   end
endmodule

module wide_compare_seq #(
   parameter int unsigned WORD_W = 16,
   parameter int unsigned NWORDS = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [1:0]               op,
   input  logic [NWORDS*WORD_W-1:0] a,
   input  logic [NWORDS*WORD_W-1:0] b,
   output logic                     busy,
   output logic                     done,
   output logic                     result
);
   localparam int unsigned IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_EQ, ST_LT, ST_DONE} state_t;

   state_t                          state_q, state_d;
   logic [IDX_W-1:0]                idx_q, idx_d;
   logic [1:0]                      op_q, op_d;
   logic [NWORDS-1:0][WORD_W-1:0]   a_q, a_d, b_q, b_d;
   logic                            result_q, result_d;

   logic [1:0]                      cmp_op;
   logic [WORD_W-1:0]               cmp_in0, cmp_in1;
   logic                            cmp_out;

   always_comb begin
      cmp_op  = (state_q == ST_LT) ? 2'b01 : 2'b00;
      cmp_in0 = a_q[idx_q];
      cmp_in1 = b_q[idx_q];
`ifdef CMP_SIGNED_EN
      // Flipping the sign bit maps two's complement onto unsigned order for the top word.
      if (idx_q == IDX_W'(NWORDS - 1)) begin
         cmp_in0[WORD_W-1] = ~cmp_in0[WORD_W-1];
         cmp_in1[WORD_W-1] = ~cmp_in1[WORD_W-1];
      end
`endif
   end

   c_alu #(.W(WORD_W)) u_cmp (
      .op  (cmp_op),
      .in0 (cmp_in0),
      .in1 (cmp_in1),
      .out (cmp_out)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               op_d    = op;
               a_d     = a;
               b_d     = b;
               idx_d   = IDX_W'(NWORDS - 1);
               state_d = ST_EQ;
            end
         end
         ST_EQ: begin
            if (cmp_out) begin
               if (idx_q == '0) begin
                  // All words equal: EQ and GEQ true, NEQ and LT false.
                  state_d  = ST_DONE;
                  result_d = (op_q == 2'b00) || (op_q == 2'b11);
               end else begin
                  idx_d = idx_q - 1'b1;
               end
            end else if (!op_q[0]) begin
               state_d  = ST_DONE;
               result_d = (op_q == 2'b10);
            end else begin
               state_d = ST_LT;
            end
         end
         ST_LT: begin
            state_d  = ST_DONE;
            result_d = (op_q == 2'b01) ? cmp_out : !cmp_out;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy   = (state_q == ST_EQ) || (state_q == ST_LT);
      done   = (state_q == ST_DONE);
      result = result_q;
   end
endmodule

// File: tb/tb_wide_compare_seq.sv
// Directed self-checking bench for wide_compare_seq (NWORDS=4, WORD_W=16).
module tb_wide_compare_seq;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  op = '0;
   logic [63:0] a = '0;
   logic [63:0] b = '0;
   logic        busy, done, result;

   int n_checks = 0;
   int n_pass   = 0;

   wide_compare_seq #(.WORD_W(16), .NWORDS(4)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else
         n_pass++;
   endtask

   // Called #1 after a rising edge with the DUT idle.
   task automatic run(input string tag, input logic [1:0] o, input logic [63:0] av,
                      input logic [63:0] bv, input logic exp_res, input int exp_lat,
                      input int exp_busy, input bit poke);
      int lat = 0;
      int busy_n = 0;
      start = 1'b1; op = o; a = av; b = bv;
      @(posedge clk); #1;
      start = 1'b0; a = ~av; b = '0; op = ~o;
      for (int c = 1; c <= 20; c++) begin
         if (done) begin
            lat = c;
            check({tag, "_result"}, result, exp_res);
            check({tag, "_busy_at_done"}, busy, 0);
            break;
         end
         if (busy) busy_n++;
         if (poke && c == 1) start = 1'b1;
         if (poke && c == 2) start = 1'b0;
         @(posedge clk); #1;
      end
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_busy_cycles"}, busy_n, exp_busy);
      @(posedge clk); #1;
      check({tag, "_done_pulse"}, done, 0);
      check({tag, "_result_held"}, result, exp_res);
      if (poke) begin
         for (int c = 0; c < 3; c++) begin
            check({tag, "_no_restart"}, busy, 0);
            @(posedge clk); #1;
         end
      end
   endtask

   initial begin
      logic exp_signed;
      int   dones;
      #2;
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_result", result, 0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      run("t1_eq_all",  2'b00, 64'h0001_0002_0003_0004, 64'h0001_0002_0003_0004, 1'b1, 5, 4, 1'b0);
      run("t2_lt_top",  2'b01, 64'h0001_0000_0000_0000, 64'h0003_0000_0000_0000, 1'b1, 3, 2, 1'b0);
      run("t3_geq_low", 2'b11, 64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_FFF0, 1'b1, 6, 5, 1'b0);
      run("t4_neq_ex",  2'b10, 64'h0000_0001_0000_0000, 64'h0000_0002_0000_0000, 1'b1, 3, 2, 1'b0);
      run("eq_diff0",   2'b00, 64'h0001_0002_0003_0004, 64'h0001_0002_0003_0005, 1'b0, 5, 4, 1'b0);
      run("neq_same",   2'b10, 64'hDEAD_BEEF_0000_1111, 64'hDEAD_BEEF_0000_1111, 1'b0, 5, 4, 1'b0);
      run("lt_same",    2'b01, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 1'b0, 5, 4, 1'b0);
      run("lt_gt_poke", 2'b01, 64'h0005_0000_0000_0000, 64'h0003_0000_0000_0000, 1'b0, 3, 2, 1'b1);
      run("geq_w1",     2'b11, 64'h0000_0000_1234_0000, 64'h0000_0000_1235_0000, 1'b0, 5, 4, 1'b1);

`ifdef CMP_SIGNED_EN
      exp_signed = 1'b1;
`else
      exp_signed = 1'b0;
`endif
      run("t6_signed",  2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, exp_signed, 3, 2, 1'b0);

      // Leave result=1 so the reset clearing it is visible.
      run("pre_rst",    2'b00, 64'h0, 64'h0, 1'b1, 5, 4, 1'b0);
      start = 1'b1; op = 2'b01; a = 64'd1; b = 64'd3;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      check("t5_busy_before_rst", busy, 1);
      rst = 1'b1;
      #1;
      check("t5_rst_busy", busy, 0);
      check("t5_rst_done", done, 0);
      check("t5_rst_result", result, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      dones = 0;
      for (int c = 0; c < 10; c++) begin
         if (done || busy) dones++;
         @(posedge clk); #1;
      end
      check("t5_no_late_done", dones, 0);

      run("post_rst",   2'b11, 64'h0000_0000_0000_0003, 64'h0000_0000_0000_0001, 1'b1, 6, 5, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
